// File: rtl/texture_mapper_fu_arbiter.sv
// rtl/texture_mapper_fu_arbiter.sv - shares one fixed-latency pipelined FU between NUM_REQ requesters
//
// Purpose:
//   Round-robin issue arbiter for a fully pipelined functional unit or RAM read port.
//   A LATENCY-deep {valid, id} tag pipeline remembers who owns each in-flight
//   operation, and the returning data is steered back to that owner as a one-cycle pulse.
//
// Build option:
//   TEXTURE_MAPPER_ARB_FIXED_PRIORITY_EN - when defined, the round-robin pointer is
//   removed and the lowest-index active requester always wins.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   req          - per-requester level request, held until granted
//   req_addr     - packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   fu_stall     - FU cannot accept an issue this cycle
//   grant        - one-hot-or-zero combinational issue acknowledge
//   fu_start     - issue strobe to the FU
//   fu_addr      - address of the granted requester (0 when idle)
//   fu_data_in   - FU return data, valid LATENCY cycles after fu_start
//   rsp_valid    - one-hot response pulse to the owning requester
//   rsp_data     - shared response data bus (0 when no response)
//   busy         - at least one operation in flight

module texture_mapper_fu_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic                          fu_stall,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          fu_start,
    output logic [ADDR_WIDTH-1:0]         fu_addr,
    input  logic [DATA_WIDTH-1:0]         fu_data_in,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);

    logic                found;
    logic [ID_WIDTH-1:0] grant_id;
    logic                issue;

    logic [LATENCY-1:0]  stage_valid;
    logic [ID_WIDTH-1:0] stage_id [LATENCY];
    logic                last_valid;

`ifdef TEXTURE_MAPPER_ARB_FIXED_PRIORITY_EN
    // Scan from the top down so the lowest active index is the final assignment.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                found    = 1'b1;
                grant_id = ID_WIDTH'(k);
            end
        end
    end
`else
    logic [ID_WIDTH-1:0] rr_ptr;

    // Offsets are scanned from farthest to nearest so the requester closest
    // after rr_ptr (wrapping) is the final, winning assignment.
    always_comb begin
        int idx;
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                found    = 1'b1;
                grant_id = ID_WIDTH'(idx);
            end
        end
    end

    // Pointer moves only on a real issue, so a stalled cycle leaves priority untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
        end else if (fu_start) begin
            rr_ptr <= grant_id;
        end
    end
`endif

    // Reset gates the issue path so nothing leaves the arbiter during reset.
    assign issue    = found & ~fu_stall & ~reset;
    assign fu_start = issue;

    always_comb begin
        grant   = '0;
        fu_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = issue && (grant_id == ID_WIDTH'(i));
        end
        if (issue) begin
            fu_addr = req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Tag pipeline shifts every cycle; fu_stall only blocks new issues and
    // never freezes operations already inside the FU.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                stage_id[s] <= '0;
            end
        end else begin
            stage_valid[0] <= fu_start;
            stage_id[0]    <= grant_id;
            for (int s = 1; s < LATENCY; s++) begin
                stage_valid[s] <= stage_valid[s-1];
                stage_id[s]    <= stage_id[s-1];
            end
        end
    end

    assign last_valid = stage_valid[LATENCY-1] & ~reset;

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = last_valid && (stage_id[LATENCY-1] == ID_WIDTH'(i));
        end
        if (last_valid) begin
            rsp_data = fu_data_in;
        end
    end

    assign busy = (|stage_valid) & ~reset;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!$onehot0(grant) || ((|grant) && fu_stall)) begin
                $error("texture_mapper_fu_arbiter: illegal grant %b (fu_stall=%b)", grant, fu_stall);
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_texture_mapper_fu_arbiter.sv
// tb/tb_texture_mapper_fu_arbiter.sv - directed self-checking bench for texture_mapper_fu_arbiter

module tb_texture_mapper_fu_arbiter;

`ifdef TEXTURE_MAPPER_ARB_FIXED_PRIORITY_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: NUM_REQ=4, LATENCY=3
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_addr;
    logic        fu_stall;
    logic [3:0]  grant;
    logic        fu_start;
    logic [15:0] fu_addr;
    logic [31:0] fu_data_in;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    // Second DUT: NUM_REQ=2, LATENCY=1
    logic        reset1;
    logic [1:0]  req1;
    logic [31:0] req_addr1;
    logic        stall1;
    logic [1:0]  grant1;
    logic        start1;
    logic [15:0] addr1;
    logic [31:0] data_in1;
    logic [1:0]  rspv1;
    logic [31:0] rspd1;
    logic        busy1;

    int n_vec = 0;
    int n_err = 0;

    texture_mapper_fu_arbiter u_dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .fu_stall(fu_stall),
        .grant(grant), .fu_start(fu_start), .fu_addr(fu_addr), .fu_data_in(fu_data_in),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    texture_mapper_fu_arbiter #(.NUM_REQ(2), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset1), .req(req1), .req_addr(req_addr1), .fu_stall(stall1),
        .grant(grant1), .fu_start(start1), .fu_addr(addr1), .fu_data_in(data_in1),
        .rsp_valid(rspv1), .rsp_data(rspd1), .busy(busy1)
    );

    // FU model: returns issued address + 0x100 three cycles later.
    logic [31:0] d1, d2, d3;
    always @(posedge clk) begin
        d1 <= 32'(fu_addr) + 32'h100;
        d2 <= d1;
        d3 <= d2;
    end
    assign fu_data_in = d3;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] a_of(input int i, input int t);
        return 16'((i << 12) | (16 + t));
    endfunction

    logic [3:0] vreq   [16];
    bit         vstall [16];
    bit         vrst   [16];
    int         vg     [16];

    task automatic apply_reset(input string nm);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset    = 1'b1;
            req      = 4'hF;
            fu_stall = 1'b0;
            #1;
            check($sformatf("%s rst grant", nm), 64'(grant), 64'h0);
            check($sformatf("%s rst fu_start", nm), 64'(fu_start), 64'h0);
            check($sformatf("%s rst fu_addr", nm), 64'(fu_addr), 64'h0);
            check($sformatf("%s rst rsp_valid", nm), 64'(rsp_valid), 64'h0);
            check($sformatf("%s rst busy", nm), 64'(busy), 64'h0);
        end
    endtask

    task automatic run_seq(input string nm, input int n);
        logic [3:0]  eg, ev;
        logic [15:0] ea;
        logic [31:0] ed;
        bit          eb, alive;
        apply_reset(nm);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            reset    = vrst[t];
            fu_stall = vstall[t];
            req      = vreq[t];
            for (int i = 0; i < 4; i++) req_addr[i*16 +: 16] = a_of(i, t);
            #1;
            eg = (vg[t] >= 0) ? 4'(1 << vg[t]) : 4'h0;
            ea = (vg[t] >= 0) ? a_of(vg[t], t) : 16'h0;
            ev = 4'h0;
            ed = 32'h0;
            eb = 1'b0;
            for (int k = t - 3; k < t; k++) begin
                if (k >= 0 && vg[k] >= 0) begin
                    alive = 1'b1;
                    for (int r = k + 1; r <= t; r++) if (vrst[r]) alive = 1'b0;
                    if (alive) begin
                        eb = 1'b1;
                        if (k == t - 3) begin
                            ev = 4'(1 << vg[k]);
                            ed = 32'(a_of(vg[k], k)) + 32'h100;
                        end
                    end
                end
            end
            check($sformatf("%s c%0d grant", nm, t), 64'(grant), 64'(eg));
            check($sformatf("%s c%0d fu_start", nm, t), 64'(fu_start), 64'(|eg));
            check($sformatf("%s c%0d fu_addr", nm, t), 64'(fu_addr), 64'(ea));
            check($sformatf("%s c%0d rsp_valid", nm, t), 64'(rsp_valid), 64'(ev));
            check($sformatf("%s c%0d rsp_data", nm, t), 64'(rsp_data), 64'(ed));
            check($sformatf("%s c%0d busy", nm, t), 64'(busy), 64'(eb));
        end
    endtask

    task automatic clear_tables();
        for (int t = 0; t < 16; t++) begin
            vreq[t] = 4'h0; vstall[t] = 1'b0; vrst[t] = 1'b0; vg[t] = -1;
        end
    endtask

    logic [1:0] t1_req [5];
    logic [1:0] t1_g   [5];
    logic [1:0] t1_v   [5];
    bit         t1_b   [5];

    initial begin
        reset = 1'b1; req = '0; req_addr = '0; fu_stall = 1'b0;
        reset1 = 1'b1; req1 = '0; req_addr1 = {16'h000B, 16'h000A}; stall1 = 1'b0; data_in1 = '0;

        // Sole requester 2 for four cycles: granted every cycle, four responses.
        clear_tables();
        for (int t = 0; t < 4; t++) begin vreq[t] = 4'b0100; vg[t] = 2; end
        run_seq("single", 8);

        // All four requesting: rotation starting from requester 0.
        clear_tables();
        for (int t = 0; t < 6; t++) vreq[t] = 4'b1111;
        if (FP) vg = '{0:0, 1:0, 2:0, 3:0, 4:0, 5:0, default:-1};
        else    vg = '{0:0, 1:1, 2:2, 3:3, 4:0, 5:1, default:-1};
        run_seq("all4", 10);

        // Stall in cycle 2 with req=0011: no grant, pointer held.
        clear_tables();
        for (int t = 0; t < 5; t++) vreq[t] = 4'b0011;
        vstall[2] = 1'b1;
        if (FP) vg = '{0:0, 1:0, 3:0, 4:0, default:-1};
        else    vg = '{0:0, 1:1, 3:0, 4:1, default:-1};
        run_seq("stall", 9);

        // Reset one cycle after two grants kills their responses; next grant goes to 0.
        clear_tables();
        vreq[0] = 4'b0011; vreq[1] = 4'b0011; vrst[2] = 1'b1; vreq[6] = 4'b1111;
        vg = '{0:0, 1:1, 6:0, default:-1};
        run_seq("midrst", 10);

        // req=1010 held: alternates 1,3 (fixed priority starves 3).
        clear_tables();
        for (int t = 0; t < 4; t++) vreq[t] = 4'b1010;
        if (FP) vg = '{0:1, 1:1, 2:1, 3:1, default:-1};
        else    vg = '{0:1, 1:3, 2:1, 3:3, default:-1};
        run_seq("r1010", 7);

        // LATENCY=1, NUM_REQ=2 with alternating requests.
        t1_req = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
        t1_g   = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
        t1_v   = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
        t1_b   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        repeat (2) @(negedge clk);
        #1;
        check("lat1 rst grant", 64'(grant1), 64'h0);
        check("lat1 rst busy", 64'(busy1), 64'h0);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            reset1   = 1'b0;
            req1     = t1_req[t];
            data_in1 = 32'hA0 + 32'(t);
            #1;
            check($sformatf("lat1 c%0d grant", t), 64'(grant1), 64'(t1_g[t]));
            check($sformatf("lat1 c%0d fu_addr", t), 64'(addr1),
                  (t1_g[t] == 2'b01) ? 64'h0A : (t1_g[t] == 2'b10) ? 64'h0B : 64'h0);
            check($sformatf("lat1 c%0d rsp_valid", t), 64'(rspv1), 64'(t1_v[t]));
            check($sformatf("lat1 c%0d rsp_data", t), 64'(rspd1),
                  (t1_v[t] != 2'b00) ? 64'hA0 + 64'(t) : 64'h0);
            check($sformatf("lat1 c%0d busy", t), 64'(busy1), 64'(t1_b[t]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/texture_mapper_fu_arbiter.md
Name: texture_mapper_fu_arbiter

Overview:
- Shares one fixed-latency, fully pipelined functional unit (FU or RAM read port) between NUM_REQ requesters in the texture mapper datapath.
- Arbitrates issue slots round-robin and drives the FU start and address.
- Tracks which requester owns each in-flight operation with a LATENCY-deep tag pipeline.
- Steers each returning result back to its owner as a one-cycle valid pulse. Each requester captures the pulse in its own data receiver FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- LATENCY, 3, cycles from fu_start to valid fu_data_in (≥1).
- DATA_WIDTH, 32, FU return data width.
- ADDR_WIDTH, 16, per-request address/operand width.
- ID_WIDTH, $clog2(NUM_REQ) (min 1), tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester issue request, level; held until granted.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- fu_stall  in  1  FU cannot accept an issue this cycle.
- grant  out  NUM_REQ  one-hot or zero; combinational issue acknowledge.
- fu_start  out  1  issue strobe to FU.
- fu_addr  out  ADDR_WIDTH  address of granted requester.
- fu_data_in  in  DATA_WIDTH  FU return data, valid LATENCY cycles after fu_start.
- rsp_valid  out  NUM_REQ  one-hot response pulse to owner.
- rsp_data  out  DATA_WIDTH  response data, shared bus.
- busy  out  1  any operation in flight.

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset clears the tag pipeline and sets the RR pointer to NUM_REQ-1, so requester 0 has top priority first.
- Outputs during and after reset: grant=0, fu_start=0, fu_addr=0, rsp_valid=0, busy=0.
- Grant is combinational in the same cycle.
  - If fu_stall=1 or req=0: grant=0.
  - Otherwise grant the first set req bit searching from (ptr+1) mod NUM_REQ upward, wrapping.
- fu_start = |grant.
- fu_addr = req_addr slice of the granted index when fu_start=1; else 0.
- RR pointer: updates to the granted index on the clock edge when fu_start=1; otherwise holds.
- A requester that keeps req high is never granted twice in a row while another requester is requesting.
- A sole requester is granted every non-stalled cycle (throughput 1/cycle).
- Tag pipeline: LATENCY stages of {valid, id}.
  - Stage 0 loads {fu_start, granted id} each cycle.
  - It shifts every cycle unconditionally; fu_stall blocks issue only and never freezes in-flight ops.
- LATENCY=1: a single register stage.
- Response: when the last stage is valid, rsp_valid[id]=1 for exactly that cycle, and rsp_data = fu_data_in (combinational pass-through, no extra latency).
- When the last stage is invalid: rsp_valid=0 and rsp_data=0.
- Result: rsp_valid[i] asserts exactly LATENCY cycles after the grant[i] cycle.
- Responses cannot be back-pressured; owners must always accept them.
- busy = OR of all stage valid bits.
- Reset mid-operation discards all in-flight tags. No rsp_valid appears for ops issued before reset, even though the FU may still return data.
- Simultaneous events:
  - An issue and a response for the same requester in one cycle are independent and both occur.
  - req deasserting in the same cycle it would be granted yields no grant; req is sampled combinationally.
- Simulation check (translate_off): error and $finish if grant is not one-hot-or-zero, or if a grant occurs while fu_stall=1.

Optional Feature:
- Macro: TEXTURE_MAPPER_ARB_FIXED_PRIORITY_EN.
- Defined: the RR pointer is removed and the lowest-index active requester always wins; all other behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single requester, LATENCY=3: req[2]=1 for 4 cycles with addrs 0x10..0x13, FU returns addr+0x100 → grant[2] all 4 cycles; rsp_valid[2] pulses cycles 3..6 with data 0x110..0x113.
- All 4 requesting continuously from reset → grant order 0,1,2,3,0,1; each rsp_valid[i] lands 3 cycles after its grant and carries its own data.
- fu_stall=1 on cycle 2 with req=0b0011 → no grant in cycle 2, ptr unchanged; grant resumes at the next RR requester in cycle 3; in-flight responses still emerge on schedule.
- Reset asserted 1 cycle after two grants → rsp_valid stays 0 for all subsequent cycles; busy=0 the cycle after reset; the next grant goes to requester 0.
- LATENCY=1, NUM_REQ=2, alternating req → rsp_valid one cycle after each grant; busy deasserts 1 cycle after the final grant.
- Macro defined, req=0b1010 held → grant[1] every cycle and requester 3 starved; macro undefined → grants alternate 1,3.
